// File: rtl/bn_pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: an N-bit operation is split into BLOCK-bit
// lookahead blocks spread over STAGES registered stages, with valid/ready flow control.
module bn_pipelined_cla_adder #(
    parameter int N      = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         c_out,
    output logic         overflow,
    output logic         zero
);
    localparam int BPS = (N / BLOCK) / STAGES;
    localparam int W   = BPS * BLOCK;

    // Operands travel right-aligned, so every stage consumes the low W bits of its input.
    logic [N-1:0]      stg_x   [STAGES];
    logic [N-1:0]      stg_y   [STAGES];
    logic [N-1:0]      stg_sum [STAGES];
    logic [STAGES-1:0] stg_c;
    logic [STAGES-1:0] stg_take;
    logic [STAGES-1:0] full;
    logic [STAGES:0]   adv;

    assign adv[STAGES] = out_ready;
    assign in_ready    = adv[0] & ~flush;

    assign stg_x[0]    = x;
    assign stg_y[0]    = sub ? ~y : y;
    assign stg_c[0]    = sub | c_in;
    assign stg_sum[0]  = '0;
    assign stg_take[0] = in_valid & in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         co;
        logic [N-1:0] sum_next;
        logic         carry;
        logic         rip;
        logic         blk_g;
        logic         blk_p;
        logic         bit_g;
        logic         bit_p;

        assign a      = stg_x[k][W-1:0];
        assign b      = stg_y[k][W-1:0];
        assign adv[k] = ~full[k] | adv[k+1];

        // Blocks are chained by lookahead; bits inside a block ripple from the block carry-in.
        always_comb begin
            carry = stg_c[k];
            rip   = 1'b0;
            blk_g = 1'b0;
            blk_p = 1'b1;
            bit_g = 1'b0;
            bit_p = 1'b0;
            s     = '0;
            for (int j = 0; j < BPS; j++) begin
                rip   = carry;
                blk_g = 1'b0;
                blk_p = 1'b1;
                for (int i = 0; i < BLOCK; i++) begin
                    bit_g            = a[j*BLOCK+i] & b[j*BLOCK+i];
                    bit_p            = a[j*BLOCK+i] | b[j*BLOCK+i];
                    s[j*BLOCK+i]     = a[j*BLOCK+i] ^ b[j*BLOCK+i] ^ rip;
                    rip              = bit_g | (bit_p & rip);
                    blk_g            = bit_g | (bit_p & blk_g);
                    blk_p            = blk_p & bit_p;
                end
                carry = blk_g | (blk_p & carry);
            end
        end

        assign co       = carry;
        assign sum_next = stg_sum[k] | (N'(s) << (k * W));

        if (k < STAGES - 1) begin : g_mid
            logic [N-1:0] x_q;
            logic [N-1:0] y_q;
            logic [N-1:0] sum_q;
            logic         c_q;
            logic         v_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q   <= 1'b0;
                    x_q   <= '0;
                    y_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                end else begin
                    if (flush) begin
                        v_q <= 1'b0;
                    end else if (adv[k]) begin
                        v_q <= stg_take[k];
                    end
                    if (adv[k] && stg_take[k]) begin
                        x_q   <= stg_x[k] >> W;
                        y_q   <= stg_y[k] >> W;
                        sum_q <= sum_next;
                        c_q   <= co;
                    end
                end
            end

            assign stg_x[k+1]    = x_q;
            assign stg_y[k+1]    = y_q;
            assign stg_sum[k+1]  = sum_q;
            assign stg_c[k+1]    = c_q;
            assign stg_take[k+1] = v_q;
            assign full[k]       = v_q;
        end else begin : g_last
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            logic c_msb;
            assign c_msb = a[W-1] ^ b[W-1] ^ s[W-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    z         <= '0;
                    c_out     <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end else begin
                    if (flush) begin
                        out_valid <= 1'b0;
                    end else if (adv[k]) begin
                        out_valid <= stg_take[k];
                    end
                    if (adv[k] && stg_take[k]) begin
                        z        <= sum_next;
                        c_out    <= co;
                        overflow <= c_msb ^ co;
                        zero     <= ~|sum_next;
                    end
                end
            end

            assign full[k] = out_valid;
        end
    end

endmodule

// File: tb/tb_bn_pipelined_cla_adder.sv
// Self-checking bench for bn_pipelined_cla_adder: hand-computed vectors streamed through
// a scoreboard, plus directed latency, backpressure, flush and reset sequences.
module tb_bn_pipelined_cla_adder;
    localparam int N  = 16;
    localparam int NV = 12;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         cin;
        logic         sub;
        logic [N-1:0] ez;
        logic         ec;
        logic         eov;
        logic         ezero;
    } vec_t;

    vec_t vecs [NV];

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [N-1:0] x         = '0;
    logic [N-1:0] y         = '0;
    logic         c_in      = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] z;
    logic         c_out;
    logic         overflow;
    logic         zero;

    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;
    int   exp_q[$];
    logic last_ov  = 1'b0;
    logic last_ir  = 1'b0;

    bn_pipelined_cla_adder #(.N(N), .BLOCK(4), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkWord(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input int idx);
        checks++;
        if ({z, c_out, overflow, zero} !==
            {vecs[idx].ez, vecs[idx].ec, vecs[idx].eov, vecs[idx].ezero}) begin
            errors++;
            $display("[TB] FAIL result_vec%0d: got z=%h c_out=%b ovf=%b zero=%b, expected z=%h c_out=%b ovf=%b zero=%b",
                     idx, z, c_out, overflow, zero,
                     vecs[idx].ez, vecs[idx].ec, vecs[idx].eov, vecs[idx].ezero);
        end
    endtask

    // One clock cycle: drive at the falling edge, then check any presented result.
    task automatic applyStimulus(input logic v, input int idx, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = v;
        flush     = fl;
        out_ready = ordy;
        x         = vecs[idx].x;
        y         = vecs[idx].y;
        c_in      = vecs[idx].cin;
        sub       = vecs[idx].sub;
        #1;
        last_ov = out_valid;
        last_ir = in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got out_valid=1 z=%h, expected no result", z);
            end else begin
                checkOutput(exp_q[0]);
                if (ordy) void'(exp_q.pop_front());
            end
        end
        if (fl) begin
            exp_q.delete();
        end else if (v && in_ready) begin
            exp_q.push_back(idx);
            accepted++;
        end
    endtask

    initial begin
        //            x         y         cin   sub   z         c     ovf   zero
        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, 1'b0};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkFlag("reset_out_valid", out_valid, 1'b0);
        checkWord("reset_z", z, '0);
        checkFlag("reset_c_out", c_out, 1'b0);
        checkFlag("reset_overflow", overflow, 1'b0);
        checkFlag("reset_zero", zero, 1'b0);
        rst_n = 1'b1;
        #1;
        checkFlag("in_ready_after_reset", in_ready, 1'b1);

        $display("[TB] latency");
        applyStimulus(1'b1, 0, 1'b1, 1'b0);
        checkFlag("lat_accept", last_ir, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("lat_cycle1_out_valid", last_ov, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("lat_cycle2_out_valid", last_ov, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("lat_single_result", last_ov, 1'b0);

        $display("[TB] full-rate stream");
        for (int i = 0; i < NV; i++) begin
            applyStimulus(1'b1, i, 1'b1, 1'b0);
            checkFlag($sformatf("stream_in_ready_%0d", i), last_ir, 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkCount("stream_drained", exp_q.size(), 0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("stream_idle", last_ov, 1'b0);

        $display("[TB] backpressure");
        accepted = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4 + i, 1'b0, 1'b0);
        checkCount("bp_accepted", accepted, 2);
        checkFlag("bp_in_ready_blocked", last_ir, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("bp_drain1_valid", last_ov, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("bp_drain2_valid", last_ov, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("bp_drain_done", last_ov, 1'b0);
        checkCount("bp_queue_empty", exp_q.size(), 0);

        $display("[TB] flush");
        applyStimulus(1'b1, 8, 1'b0, 1'b0);
        applyStimulus(1'b1, 9, 1'b0, 1'b0);
        applyStimulus(1'b1, 10, 1'b0, 1'b1);
        checkFlag("flush_in_ready", last_ir, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("flush_cleared_c1", last_ov, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("flush_cleared_c2", last_ov, 1'b0);
        applyStimulus(1'b1, 3, 1'b1, 1'b1);
        checkFlag("flush_idle_in_ready", last_ir, 1'b0);
        applyStimulus(1'b1, 11, 1'b1, 1'b0);
        checkFlag("postflush_accept", last_ir, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("postflush_c1", last_ov, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("postflush_c2", last_ov, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("postflush_done", last_ov, 1'b0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 5, 1'b1, 1'b0);
        applyStimulus(1'b1, 6, 1'b1, 1'b0);
        applyStimulus(1'b1, 7, 1'b1, 1'b0);
        checkFlag("mid_pre_reset_valid", last_ov, 1'b1);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkFlag("mid_reset_out_valid", out_valid, 1'b0);
        checkWord("mid_reset_z", z, '0);
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1, 1'b1, 1'b0);
        checkFlag("mid_after_accept", last_ir, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("mid_after_c1", last_ov, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("mid_after_c2", last_ov, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkFlag("mid_after_alone", last_ov, 1'b0);
        checkCount("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
